dram_port_arbiter: RTL and testbench

//  Shares the single-port data DRAM between two requesters: port 0 (pipeline MEM stage) and port 1 (debug/program loader).

---
 rtl/dram_arb_pkg.sv | 24 ++
 rtl/dram_byte_merge.sv | 13 +
 rtl/dram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_dram_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared types and helpers for the DRAM port arbiter
package dram_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } arb_state_e;

    localparam logic [31:0] DRAM_BASE = 32'h0000_4000;

    // Word-aligned compare in 34 bits so a window touching the top of the map cannot wrap
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] depth_words);
        logic [33:0] a;
        logic [33:0] lo;
        logic [33:0] hi;
        a  = {2'b00, addr[31:2], 2'b00};
        lo = {2'b00, base};
        hi = lo + ({2'b00, depth_words} << 2);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/dram_byte_merge.sv
// rtl/dram_byte_merge.sv - per-lane merge of store data into an existing DRAM word
module dram_byte_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  be_i,
    output logic [31:0] merged_o
);

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        assign merged_o[8*lane +: 8] = be_i[lane] ? new_i[8*lane +: 8] : old_i[8*lane +: 8];
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - two-port arbiter for the data DRAM with window check and sub-word RMW
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DRAM_BASE,
    parameter int unsigned DEPTH_WORDS  = 16384,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] dram_a,
    output logic        dram_we,
    output logic [31:0] dram_d,
    input  logic [31:0] dram_spo
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e  state_q;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0] merge_q, addr_q;
    logic        port_q;
    logic        rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        idle, force_m1, gnt0, gnt1, any_gnt, sel;
    logic        sel_we, sel_inwin, full_wr, part_wr, resp_err;
    logic [31:0] sel_addr, sel_wdata, resp_rdata, merged;
    logic [3:0]  sel_be;

    always_comb begin
        idle      = rst_n && (state_q == IDLE);
        force_m1  = m1_req && (starve_q == STARVE_MAX);
        gnt1      = idle && m1_req && (force_m1 || !m0_req);
        gnt0      = idle && m0_req && !gnt1;
        any_gnt   = gnt0 || gnt1;
        sel       = gnt1;
        sel_we    = sel ? m1_we    : m0_we;
        sel_addr  = sel ? m1_addr  : m0_addr;
        sel_wdata = sel ? m1_wdata : m0_wdata;
        sel_be    = sel ? m1_be    : m0_be;
        sel_inwin = in_window(sel_addr, BASE_ADDR, DEPTH_WORDS);
        full_wr   = any_gnt && sel_we && sel_inwin && (sel_be == 4'hF);
        part_wr   = any_gnt && sel_we && sel_inwin && (sel_be != 4'hF) && (sel_be != 4'h0);
        resp_err  = !sel_inwin;
        resp_rdata = (!sel_we && sel_inwin) ? dram_spo : 32'h0;

        if (m1_req && !gnt1) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
        end else begin
            starve_d = '0;
        end
    end

    // In IDLE the DRAM sees the selected requester so spo already holds the old word for a merge
    dram_byte_merge u_merge (
        .old_i   (dram_spo),
        .new_i   (sel_wdata),
        .be_i    (sel_be),
        .merged_o(merged)
    );

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign dram_a    = (state_q == RMW_WR) ? addr_q  : sel_addr;
    assign dram_d    = (state_q == RMW_WR) ? merge_q : sel_wdata;
    assign dram_we   = rst_n && ((state_q == RMW_WR) || full_wr);
    assign m0_rvalid = rvalid0_q;
    assign m0_rdata  = rdata0_q;
    assign m0_err    = err0_q;
    assign m1_rvalid = rvalid1_q;
    assign m1_rdata  = rdata1_q;
    assign m1_err    = err1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            merge_q   <= '0;
            addr_q    <= '0;
            port_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            starve_q  <= starve_d;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (part_wr) begin
                        merge_q <= merged;
                        addr_q  <= sel_addr;
                        port_q  <= sel;
                        state_q <= RMW_WR;
                    end else if (gnt1) begin
                        rvalid1_q <= 1'b1;
                        rdata1_q  <= resp_rdata;
                        err1_q    <= resp_err;
                    end else if (gnt0) begin
                        rvalid0_q <= 1'b1;
                        rdata0_q  <= resp_rdata;
                        err0_q    <= resp_err;
                    end
                end
                RMW_WR: begin
                    state_q <= IDLE;
                    if (port_q) begin
                        rvalid1_q <= 1'b1;
                        rdata1_q  <= '0;
                        err1_q    <= 1'b0;
                    end else begin
                        rvalid0_q <= 1'b1;
                        rdata0_q  <= '0;
                        err0_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - scoreboard bench for dram_port_arbiter with behavioural DRAM model
module tb_dram_port_arbiter;

    logic        clk, rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] dram_a, dram_d, dram_spo;
    logic        dram_we;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    dram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .dram_a(dram_a), .dram_we(dram_we), .dram_d(dram_d), .dram_spo(dram_spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic in_win(input logic [31:0] a);
        return (a[31:2] >= 30'h1000) && (a[31:2] < 30'h5000);
    endfunction

    function automatic logic [13:0] widx(input logic [31:0] a);
        logic [31:0] o;
        o = a - 32'h4000;
        return o[15:2];
    endfunction

    function automatic logic [31:0] pv(input int i);
        return (32'h1000_0001 * (i + 1)) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (new_w & mask) | (old_w & ~mask);
    endfunction

    // Behavioural DRAM with asynchronous read, written only here
    logic [31:0] tb_mem [0:16383];
    assign dram_spo = in_win(dram_a) ? tb_mem[widx(dram_a)] : 32'hBAD0_BAD0;
    always @(posedge clk) if (dram_we && in_win(dram_a)) tb_mem[widx(dram_a)] <= dram_d;

    // Reference model state
    typedef struct { logic [31:0] rdata; logic err; bit chk; int due; } resp_t;
    resp_t q0[$];
    resp_t q1[$];
    logic [31:0] ref_mem [0:16383];
    int starve = 0;
    bit busy = 0;
    logic [31:0] rmw_addr, rmw_data;
    bit rmw_port;
    bit glog_en = 0;
    int glog[$];

    task automatic push(input bit p, input logic [31:0] rd, input logic er, input bit ck, input int due);
        resp_t e;
        e.rdata = rd; e.err = er; e.chk = ck; e.due = due;
        if (p) q1.push_back(e); else q0.push_back(e);
    endtask

    task automatic chk_port(input bit p, input logic rv, input logic [31:0] rd, input logic er);
        resp_t e;
        bit have;
        have = p ? (q1.size() > 0) : (q0.size() > 0);
        if (rv) begin
            checks++;
            if (!have) begin
                failures++;
                $display("FAIL rvalid%0d_unexpected cycle=%0d", p, cyc);
            end else begin
                if (p) e = q1.pop_front(); else e = q0.pop_front();
                if (e.due != cyc || e.err !== er || (e.chk && e.rdata !== rd)) begin
                    failures++;
                    $display("FAIL resp%0d cycle=%0d due=%0d err=%b exp=%b rdata=%h exp=%h",
                             p, cyc, e.due, er, e.err, rd, e.rdata);
                end
            end
        end else if (have) begin
            if (p) e = q1[0]; else e = q0[0];
            if (e.due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL resp%0d_missing cycle=%0d due=%0d", p, cyc, e.due);
                if (p) void'(q1.pop_front()); else void'(q0.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        bit eg0, eg1, p, we, exp_we;
        logic [31:0] a, d, exp_a, exp_d;
        logic [3:0] be;
        cyc++;
        if (!rst_n) begin
            checks++;
            if (m0_gnt || m1_gnt || dram_we || m0_rvalid || m1_rvalid || m0_err || m1_err ||
                m0_rdata != 0 || m1_rdata != 0) begin
                failures++;
                $display("FAIL reset_outputs gnt=%b%b we=%b rv=%b%b err=%b%b rd0=%h rd1=%h req=0000 exp=0",
                         m0_gnt, m1_gnt, dram_we, m0_rvalid, m1_rvalid, m0_err, m1_err, m0_rdata, m1_rdata);
            end
            q0.delete(); q1.delete();
            busy = 0; starve = 0;
        end else begin
            chk_port(0, m0_rvalid, m0_rdata, m0_err);
            chk_port(1, m1_rvalid, m1_rdata, m1_err);
            eg1 = !busy && m1_req && (starve == 4 || !m0_req);
            eg0 = !busy && m0_req && !eg1;
            checks++;
            if (m0_gnt !== eg0 || m1_gnt !== eg1) begin
                failures++;
                $display("FAIL grant cycle=%0d gnt=%b%b exp=%b%b", cyc, m0_gnt, m1_gnt, eg0, eg1);
            end
            if (glog_en) begin
                if (m0_gnt) glog.push_back(0);
                if (m1_gnt) glog.push_back(1);
            end
            exp_we = 0; exp_a = 0; exp_d = 0;
            if (busy) begin
                exp_we = 1; exp_a = rmw_addr; exp_d = rmw_data;
                ref_mem[widx(rmw_addr)] = rmw_data;
                push(rmw_port, 0, 0, 0, cyc + 1);
                busy = 0;
            end else if (eg0 || eg1) begin
                p  = eg1;
                we = p ? m1_we : m0_we;
                a  = p ? m1_addr : m0_addr;
                d  = p ? m1_wdata : m0_wdata;
                be = p ? m1_be : m0_be;
                if (!in_win(a)) push(p, 0, 1, 1, cyc + 1);
                else if (!we) push(p, ref_mem[widx(a)], 0, 1, cyc + 1);
                else if (be == 4'hF) begin
                    exp_we = 1; exp_a = a; exp_d = d;
                    ref_mem[widx(a)] = d;
                    push(p, 0, 0, 0, cyc + 1);
                end else if (be == 4'h0) push(p, 0, 0, 0, cyc + 1);
                else begin
                    rmw_addr = a; rmw_port = p; busy = 1;
                    rmw_data = lane_merge(ref_mem[widx(a)], d, be);
                end
            end
            checks++;
            if (dram_we !== exp_we || (exp_we && (dram_d !== exp_d || dram_a[31:2] !== exp_a[31:2]))) begin
                failures++;
                $display("FAIL dram_write cycle=%0d we=%b exp=%b a=%h exp=%h d=%h exp=%h",
                         cyc, dram_we, exp_we, dram_a, exp_a, dram_d, exp_d);
            end
            if (m1_req && !eg1) starve = (starve < 4) ? starve + 1 : 4;
            else starve = 0;
        end
    end

    task automatic op0(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be; m0_req = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (m0_gnt) begin
                @(posedge clk); #1;
                m0_req = 1'b0;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL m0_grant_timeout addr=%h waited=200 limit=200", a);
        m0_req = 1'b0;
    endtask

    task automatic op1(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be; m1_req = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (m1_gnt) begin
                @(posedge clk); #1;
                m1_req = 1'b0;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL m1_grant_timeout addr=%h waited=200 limit=200", a);
        m1_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic rand_fields(output logic we, output logic [31:0] a, output logic [31:0] d,
                               output logic [3:0] be);
        int r;
        r  = $urandom_range(0, 19);
        we = 1'($urandom_range(0, 1));
        a  = 32'h4000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
        if (r == 0) a = 32'h3FFC;
        else if (r == 1) a = 32'h1_4000;
        else if (r == 2) a = 32'h1_3FFC;
        else if (r == 3) a = $urandom | 32'h8000_0000;
        d  = $urandom;
        be = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) be = 4'hF;
    endtask

    initial begin
        logic we;
        logic [31:0] a, d;
        logic [3:0] be;
        rst_n = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h4000; m0_wdata = 32'h1; m0_be = 4'hF;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4004; m1_wdata = 32'h0; m1_be = 4'h0;
        idle(3);
        m0_req = 1'b0; m1_req = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 16; i++) op0(1, 32'h4000 + 4 * i, pv(i), 4'hF);
        op0(1, 32'h1_3FFC, 32'hC0FF_EE00, 4'hF);

        op0(1, 32'h4000, 32'hDEAD_BEEF, 4'hF);
        op0(0, 32'h4000, 0, 4'h0);
        expect32("t1_read_rdata", m0_rdata, 32'hDEAD_BEEF);
        expect32("t1_mem_word", tb_mem[0], 32'hDEAD_BEEF);

        op0(1, 32'h4004, 32'h1122_3344, 4'hF);
        fork
            op1(1, 32'h4004, 32'h0000_AA00, 4'b0010);
            begin idle(1); op0(0, 32'h4004, 0, 4'h0); end
        join
        expect32("t2_merged_read", m0_rdata, 32'h1122_AA44);
        expect32("t2_mem_word", tb_mem[1], 32'h1122_AA44);

        op0(1, 32'h4008, 32'h1234_5678, 4'h0);
        expect32("t6_err", {31'h0, m0_err}, 32'h0);
        idle(1);
        expect32("t6_mem_unchanged", tb_mem[2], pv(2));

        op0(0, 32'h3FFC, 0, 4'h0);
        expect32("t4_low_err_rdata", {m0_err, m0_rdata[30:0]}, 32'h8000_0000);
        op0(0, 32'h1_4000, 0, 4'h0);
        expect32("t4_high_err_rdata", {m0_err, m0_rdata[30:0]}, 32'h8000_0000);
        idle(2);

        glog.delete();
        glog_en = 1;
        fork
            for (int i = 0; i < 12; i++) op0(0, 32'h4000 + 4 * (i % 16), 0, 4'h0);
            for (int i = 0; i < 3; i++)  op1(0, 32'h4020 + 4 * i, 0, 4'h0);
        join
        glog_en = 0;
        checks++;
        if (glog.size() != 15) begin
            failures++;
            $display("FAIL t3_grant_count got=%0d exp=15", glog.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (glog[i] != ((i % 5 == 4) ? 1 : 0)) begin
                    failures++;
                    $display("FAIL t3_grant_order slot=%0d got=%0d exp=%0d", i, glog[i], (i % 5 == 4) ? 1 : 0);
                    break;
                end
            end
        end
        idle(2);

        op1(1, 32'h4010, 32'hFF00_0000, 4'b1000);
        rst_n = 1'b0;
        @(negedge clk);
        expect32("t5_we_dropped", {31'h0, dram_we}, 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        op0(0, 32'h4010, 0, 4'h0);
        expect32("t5_read_old", m0_rdata, pv(4));
        expect32("t5_mem_unchanged", tb_mem[4], pv(4));

        fork
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                rand_fields(we, a, d, be);
                op0(we, a, d, be);
            end
            begin
                logic w1;
                logic [31:0] a1, d1;
                logic [3:0] b1;
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                    rand_fields(w1, a1, d1, b1);
                    op1(w1, a1, d1, b1);
                end
            end
        join

        idle(5);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain pending0=%0d pending1=%0d exp=0", q0.size(), q1.size());
        end
        for (int i = 0; i < 16; i++) expect32("final_mem", tb_mem[i], ref_mem[i]);
        expect32("final_mem_top", tb_mem[16383], ref_mem[16383]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
